cic_interpolator: RTL



---
 rtl/cic_interpolator.sv | 97 +++++++++
 1 files changed

// File: rtl/cic_interpolator.sv
// CIC interpolator: N comb stages at the input rate, zero-stuff by R, then N integrators at the output rate.
// Full-precision output; every internal value wraps modulo 2^ACC_WIDTH.
module cic_interpolator #(
    parameter int R          = 4,
    parameter int N          = 3,
    parameter int D          = 1,
    parameter int DATA_WIDTH = 12,
    localparam int ACC_WIDTH = DATA_WIDTH + N * $clog2(R * D)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] x,
    input  logic                  x_valid,
    output logic                  x_ready,
    output logic [ACC_WIDTH-1:0]  y,
    output logic                  y_valid,
    input  logic                  y_ready
);

    localparam int P_W = $clog2(R + 1);
    localparam logic [P_W-1:0] P_LOAD = P_W'(R);
    localparam logic [P_W-1:0] P_ONE  = P_W'(1);

    logic [ACC_WIDTH-1:0] dly_q   [N][D];
    logic [ACC_WIDTH-1:0] dly_d   [N][D];
    logic [ACC_WIDTH-1:0] hold_q, hold_d;
    logic [ACC_WIDTH-1:0] integ_q [N];
    logic [ACC_WIDTH-1:0] integ_d [N];
    logic [P_W-1:0]       phase_q, phase_d;
    logic                 accept, advance;
    logic [ACC_WIDTH-1:0] comb_v, stuff_u;

    // phase counts the output slots still owed for the sample in hold; 0 means idle.
    assign y_valid = (phase_q != '0);
    assign advance = y_valid && y_ready;
    assign x_ready = (phase_q == '0) || ((phase_q == P_ONE) && advance);
    assign accept  = x_valid && x_ready;
    assign y       = integ_q[N-1];
    assign stuff_u = (phase_q == P_LOAD) ? hold_q : '0;

    always_comb begin
        dly_d  = dly_q;
        hold_d = hold_q;
        comb_v = {{(ACC_WIDTH - DATA_WIDTH){x[DATA_WIDTH-1]}}, x};
        for (int k = 0; k < N; k++) begin
            if (accept) begin
                dly_d[k][0] = comb_v;
                for (int j = 1; j < D; j++) begin
                    dly_d[k][j] = dly_q[k][j-1];
                end
            end
            comb_v = comb_v - dly_q[k][D-1];
        end
        if (accept) begin
            hold_d = comb_v;
        end
    end

    always_comb begin
        phase_d = phase_q;
        if (accept) begin
            phase_d = P_LOAD;
        end else if (advance) begin
            phase_d = phase_q - P_ONE;
        end
    end

    // Every integrator reads pre-edge values, so the cascade adds one cycle per stage.
    always_comb begin
        integ_d = integ_q;
        if (advance) begin
            integ_d[0] = integ_q[0] + stuff_u;
            for (int k = 1; k < N; k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
            hold_q  <= '0;
            for (int k = 0; k < N; k++) begin
                integ_q[k] <= '0;
                for (int j = 0; j < D; j++) begin
                    dly_q[k][j] <= '0;
                end
            end
        end else begin
            phase_q <= phase_d;
            hold_q  <= hold_d;
            integ_q <= integ_d;
            dly_q   <= dly_d;
        end
    end

endmodule
